// File: rtl/loop_sequencer_pkg.sv
// Shared types and constants for the loop sequencer.
//   BITS          iteration-count width (matches the loop manager)
//   PC_BITS       program counter width
//   LOOP_LOG_CNT  log2 of the maximum nesting depth; LOOP_CNT = 1 << LOOP_LOG_CNT
package loop_sequencer_pkg;

  localparam int unsigned BITS         = 15;
  localparam int unsigned PC_BITS      = 10;
  localparam int unsigned LOOP_LOG_CNT = 3;
  localparam int unsigned LOOP_CNT     = 1 << LOOP_LOG_CNT;

  typedef logic [PC_BITS-1:0]    pc_t;
  typedef logic [LOOP_LOG_CNT:0] depth_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StUnwind,
    StHalt
  } seq_state_e;

  // body_end is computed once at push time and never re-derived.
  typedef struct packed {
    pc_t body_start;
    pc_t body_end;
  } loop_bounds_t;

endpackage

// File: rtl/loop_sequencer_if.sv
// Bundle of the fetch, issue and loop-manager signals around the loop sequencer.
//   master: the sequencer (drives pc, issue_valid, loop-manager strobes, running, error)
//   slave : the surroundings (fetch word, queue_ready, start, loop_done)
interface loop_sequencer_if;
  import loop_sequencer_pkg::*;

  logic            start;
  pc_t             start_pc;
  pc_t             pc;
  logic            instr_valid;
  logic            instr_is_loop;
  logic            instr_is_independent;
  logic [BITS-1:0] instr_iter_count;
  pc_t             instr_body_len;
  logic            instr_is_halt;
  logic            queue_ready;
  logic            issue_valid;
  logic            loop_done;
  logic            should_increment;
  logic            should_create_new_loop;
  logic [BITS-1:0] new_loop_iteration_count;
  logic            new_loop_is_inner_independent;
  logic            did_start_next_loop_iteration;
  logic            did_finish_loop;
  logic            running;
  logic            error;

  modport master (
    input  start, start_pc, instr_valid, instr_is_loop, instr_is_independent,
           instr_iter_count, instr_body_len, instr_is_halt, queue_ready, loop_done,
    output pc, issue_valid, should_increment, should_create_new_loop,
           new_loop_iteration_count, new_loop_is_inner_independent,
           did_start_next_loop_iteration, did_finish_loop, running, error
  );

  modport slave (
    output start, start_pc, instr_valid, instr_is_loop, instr_is_independent,
           instr_iter_count, instr_body_len, instr_is_halt, queue_ready, loop_done,
    input  pc, issue_valid, should_increment, should_create_new_loop,
           new_loop_iteration_count, new_loop_is_inner_independent,
           did_start_next_loop_iteration, did_finish_loop, running, error
  );

endinterface

// File: rtl/loop_sequencer_pc_stack.sv
// LOOP_CNT-deep stack of loop body bounds.
//   clk, reset  clock, async active-high reset (empties the stack)
//   push, pop   push din / drop the top entry (ignored when full / empty)
//   din         bounds to push
//   top         innermost bounds (zero when empty)
//   below_end   body_end of the entry under top (meaningful when depth >= 2)
//   depth       number of valid entries
//   full, empty occupancy flags
module loop_sequencer_pc_stack
  import loop_sequencer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  loop_bounds_t din,
  output loop_bounds_t top,
  output pc_t          below_end,
  output depth_t       depth,
  output logic         full,
  output logic         empty
);

  loop_bounds_t            mem_q [LOOP_CNT];
  depth_t                  depth_q;
  logic [LOOP_LOG_CNT-1:0] wr_idx;
  logic [LOOP_LOG_CNT-1:0] top_idx;
  logic [LOOP_LOG_CNT-1:0] below_idx;

  assign wr_idx    = depth_q[LOOP_LOG_CNT-1:0];
  assign top_idx   = LOOP_LOG_CNT'(depth_q - depth_t'(1));
  assign below_idx = LOOP_LOG_CNT'(depth_q - depth_t'(2));

  assign empty     = (depth_q == '0);
  assign full      = (depth_q == depth_t'(LOOP_CNT));
  assign depth     = depth_q;
  assign top       = empty ? '0 : mem_q[top_idx];
  assign below_end = mem_q[below_idx].body_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      for (int i = 0; i < LOOP_CNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !full) begin
      mem_q[wr_idx] <= din;
      depth_q       <= depth_q + depth_t'(1);
    end else if (pop && !empty) begin
      depth_q <= depth_q - depth_t'(1);
    end
  end

endmodule

// File: rtl/loop_sequencer.sv
// Issue-side driver for the nested-loop manager: walks the pc, pushes/pops loop bounds and
// decides per issued instruction whether to advance, jump back to the body start, or finish.
//   clk    clock
//   reset  async active-high; clears pc, state, stack and error
//   bus    loop_sequencer_if.master: fetch word in, pc / issue / loop-manager strobes out
module loop_sequencer
  import loop_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  loop_sequencer_if.master       bus
);

  seq_state_e   state_q, state_d;
  pc_t          pc_q, pc_d;
  logic         error_q, error_d;

  loop_bounds_t top;
  loop_bounds_t push_din;
  pc_t          below_end;
  depth_t       depth;
  logic         full, empty;
  logic         push, pop;

  logic         fire;
  logic         resolve;
  logic         bad_create;
  logic         at_end;
  logic         below_ends_here;
  pc_t          loop_end;
  logic         issue, inc, create, next_iter, finish;

  loop_sequencer_pc_stack u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (push_din),
    .top       (top),
    .below_end (below_end),
    .depth     (depth),
    .full      (full),
    .empty     (empty)
  );

  assign fire       = (state_q == StRun) && bus.instr_valid && bus.queue_ready;
  assign loop_end   = pc_q + bus.instr_body_len;
  assign push_din   = '{body_start: pc_q + 1'b1, body_end: loop_end};
  assign bad_create = (bus.instr_body_len == '0) || full || (!empty && (loop_end > top.body_end));
  assign at_end     = !empty && (top.body_end == pc_q);
  // After popping the innermost loop, does the enclosing loop also end on this pc?
  assign below_ends_here = (depth > depth_t'(1)) && (below_end == pc_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    error_d   = error_q;
    push      = 1'b0;
    pop       = 1'b0;
    issue     = 1'b0;
    inc       = 1'b0;
    create    = 1'b0;
    next_iter = 1'b0;
    finish    = 1'b0;
    resolve   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          pc_d    = bus.start_pc;
        end
      end
      StRun: begin
        if (fire) begin
          if (bus.instr_is_loop) begin
            if (bus.instr_iter_count == '0) begin
              // Zero-trip loop: skip the body entirely, loop manager untouched.
              pc_d = loop_end + 1'b1;
            end else if (bad_create) begin
              error_d = 1'b1;
              state_d = StHalt;
            end else begin
              push   = 1'b1;
              create = 1'b1;
              inc    = 1'b1;
              pc_d   = pc_q + 1'b1;
            end
          end else if (bus.instr_is_halt) begin
            state_d = StIdle;
          end else begin
            issue   = 1'b1;
            inc     = 1'b1;
            resolve = 1'b1;
          end
        end
      end
      StUnwind: begin
        // loop_done already reflects the enclosing loop, which ends on this same pc.
        inc     = 1'b1;
        resolve = 1'b1;
      end
      default: ;
    endcase

    if (resolve) begin
      if (!at_end) begin
        pc_d = pc_q + 1'b1;
      end else if (!bus.loop_done) begin
        next_iter = 1'b1;
        pc_d      = top.body_start;
        state_d   = StRun;
      end else begin
        finish = 1'b1;
        pop    = 1'b1;
        if (below_ends_here) begin
          state_d = StUnwind;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = StRun;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      error_q <= error_d;
    end
  end

  assign bus.pc                            = pc_q;
  assign bus.issue_valid                   = issue;
  assign bus.should_increment              = inc;
  assign bus.should_create_new_loop        = create;
  assign bus.did_start_next_loop_iteration = next_iter;
  assign bus.did_finish_loop               = finish;
  assign bus.new_loop_iteration_count      = bus.instr_iter_count;
  assign bus.new_loop_is_inner_independent = bus.instr_is_independent;
  assign bus.running                       = (state_q == StRun) || (state_q == StUnwind);
  assign bus.error                         = error_q;

endmodule
